// File: rtl/mem_readback_streamer_if.sv
// mem_readback_streamer_if: RAM port B and beat stream bundle for the readback streamer
interface mem_readback_streamer_if #(
   parameter int DATA_W = 48,
   parameter int ADDR_W = 10,
   parameter int OUT_W  = 16
);
   logic [ADDR_W-1:0] addr_b;
   logic              we_b;
   logic [DATA_W-1:0] q_b;
   logic [OUT_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   modport master (output addr_b, we_b, out_data, out_valid, out_last, input q_b, out_ready);
   modport slave  (input addr_b, we_b, out_data, out_valid, out_last, output q_b, out_ready);
endinterface

// File: rtl/mem_readback_streamer.sv
// mem_readback_streamer: reads a block of RAM words and streams each as three beats, MSB slice first
module mem_readback_streamer #(
   parameter int DATA_W = 48,
   parameter int ADDR_W = 10,
   parameter int OUT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W:0]      count,
   output logic                 busy,
   output logic                 done,
   mem_readback_streamer_if.master bus
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ISSUE = 3'd1;
   localparam logic [2:0] READ  = 3'd2;
   localparam logic [2:0] SEND  = 3'd3;
   localparam logic [2:0] FIN   = 3'd4;
   localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
   logic [2:0]        state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic [DATA_W-1:0] shreg;
   logic [1:0]        beat;
   // Block sequencer: fetch a word, then shift it out one beat per handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         shreg     <= '0;
         beat      <= '0;
      end else begin
         case (state)
            IDLE:
               if (start) begin
                  if (count != '0) begin
                     addr      <= base_addr;
                     remaining <= (count > MAX_CNT) ? MAX_CNT : count;
                     state     <= ISSUE;
                  end else begin
                     state <= FIN;
                  end
               end
            ISSUE: state <= READ;
            READ: begin
               shreg <= bus.q_b;
               beat  <= '0;
               state <= SEND;
            end
            SEND:
               if (bus.out_ready) begin
                  if (beat == 2'd2) begin
                     beat      <= '0;
                     remaining <= remaining - ONE;
                     addr      <= addr + 1'b1;
                     state     <= (remaining == ONE) ? FIN : ISSUE;
                  end else begin
                     beat  <= beat + 2'd1;
                     shreg <= shreg << OUT_W;
                  end
               end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   assign busy          = (state == ISSUE) || (state == READ) || (state == SEND);
   assign done          = (state == FIN);
   assign bus.addr_b    = addr;
   assign bus.we_b      = 1'b0;
   assign bus.out_valid = (state == SEND);
   assign bus.out_data  = bus.out_valid ? shreg[DATA_W-1 -: OUT_W] : '0;
   assign bus.out_last  = bus.out_valid && (beat == 2'd2) && (remaining == ONE);
endmodule

// File: tb/tb_mem_readback_streamer.sv
// tb_mem_readback_streamer: randomized scoreboard bench with a RAM model and a block-level reference
module tb_mem_readback_streamer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [10:0] count = '0;
   logic        busy, done;
   mem_readback_streamer_if bus();
   mem_readback_streamer dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .count(count), .busy(busy), .done(done), .bus(bus)
   );
   always #5 clk = ~clk;
   logic [47:0] mem [1024];
   // Registered RAM model: data for addr_b appears one cycle later
   always @(posedge clk) bus.q_b <= mem[bus.addr_b];
   typedef struct { logic [15:0] d; logic l; } beat_t;
   beat_t sb[$];
   int total = 0, bad = 0, done_seen = 0, hit100 = 0, rmode = 0;
   task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", n, got, exp);
      end
   endtask
   // Ready pattern generator: always high, toggling, or random
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? !bus.out_ready : 1'($urandom_range(0, 1));
      end
   end
   logic        pst = 0, plhs = 0, pdone = 0, pl = 0;
   logic [15:0] pd = '0;
   // Monitor: scoreboard pops on handshakes, plus stall, done and we_b checks
   always @(negedge clk) begin
      if (!reset) begin
         pst = 0; plhs = 0; pdone = 0;
      end else begin
         chk("we_b", 32'(bus.we_b), 0);
         if (pst) chk("stall_hold", {14'd0, bus.out_valid, bus.out_last, bus.out_data}, {14'd0, 1'b1, pl, pd});
         if (plhs) chk("done_after_last", 32'(done), 1);
         if (pdone) chk("done_one_cycle", 32'(done), 0);
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", {15'd0, bus.out_last, bus.out_data}, 32'hffff_ffff);
            end else begin
               beat_t e;
               e = sb.pop_front();
               chk("beat", {15'd0, bus.out_last, bus.out_data}, {15'd0, e.l, e.d});
            end
         end
         if (done === 1'b1) done_seen++;
         if (busy && bus.addr_b == 10'd100) hit100++;
         pst   = bus.out_valid && !bus.out_ready;
         pd    = bus.out_data;
         pl    = bus.out_last;
         plhs  = bus.out_valid && bus.out_ready && bus.out_last;
         pdone = done;
      end
   end
   // Reference: a block is the clamped run of words from base, wrapping, each split high slice first
   task automatic push_block(int b, int c);
      int n;
      logic [47:0] w;
      logic [9:0]  a;
      n = (c > 1024) ? 1024 : c;
      for (int i = 0; i < n; i++) begin
         a = 10'(b + i);
         w = mem[a];
         sb.push_back('{w[47:32], 1'b0});
         sb.push_back('{w[31:16], 1'b0});
         sb.push_back('{w[15:0], i == n - 1});
      end
   endtask
   task automatic issue(int b, int c);
      @(negedge clk);
      base_addr = 10'(b);
      count = 11'(c);
      start = 1'b1;
      push_block(b, c);
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic wait_done(int prev);
      for (int i = 0; i < 20000 && done_seen == prev; i++) @(negedge clk);
      chk("done_reached", 32'(done_seen > prev), 1);
      chk("sb_empty", sb.size(), 0);
      repeat (2) @(negedge clk);
   endtask
   task automatic chk_reset(string t);
      chk({t, "_busy"}, 32'(busy), 0);
      chk({t, "_done"}, 32'(done), 0);
      chk({t, "_addr_b"}, 32'(bus.addr_b), 0);
      chk({t, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({t, "_out_data"}, 32'(bus.out_data), 0);
      chk({t, "_out_last"}, 32'(bus.out_last), 0);
      chk({t, "_we_b"}, 32'(bus.we_b), 0);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      int p, fv, dc;
      logic [9:0] a0;
      for (int i = 0; i < 1024; i++) mem[i] = {16'($urandom), 32'($urandom)};
      repeat (3) @(negedge clk);
      chk_reset("rst");
      reset = 1'b1;
      repeat (2) @(negedge clk);
      // single word, ready high, latency to first beat
      mem[5] = 48'h1111_2222_3333;
      rmode = 0;
      p = done_seen;
      issue(5, 1);
      fv = 0;
      for (int c = 1; c <= 6; c++) begin
         if (bus.out_valid && fv == 0) fv = c;
         if (c < 6) @(negedge clk);
      end
      chk("t1_first_valid_cycle", fv, 3);
      wait_done(p);
      // four words with toggling ready
      mem[0] = 48'h0001_0002_0003; mem[1] = 48'haaaa_bbbb_cccc;
      mem[2] = 48'h1234_5678_9abc; mem[3] = 48'hfedc_ba98_7654;
      rmode = 1;
      p = done_seen;
      issue(0, 4);
      wait_done(p);
      // address wrap 1022 -> 1023 -> 0
      rmode = 2;
      p = done_seen;
      issue(1022, 3);
      wait_done(p);
      // count zero: done only, no beats, address untouched
      rmode = 0;
      a0 = bus.addr_b;
      p = done_seen;
      issue(7, 0);
      dc = 0;
      for (int i = 1; i <= 2; i++) begin
         if (done === 1'b1 && dc == 0) dc = i;
         if (i < 2) @(negedge clk);
      end
      chk("t4_done_soon", 32'(dc != 0), 1);
      chk("t4_addr_b", 32'(bus.addr_b), 32'(a0));
      repeat (3) @(negedge clk);
      chk("t4_one_done", done_seen, p + 1);
      // reset in the middle of the second word
      p = done_seen;
      issue(0, 4);
      repeat (7) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      #1 chk_reset("midrst");
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_no_done", done_seen, p);
      issue(0, 1);
      wait_done(p);
      // start while busy is ignored
      rmode = 2;
      hit100 = 0;
      p = done_seen;
      issue(10, 3);
      repeat (4) @(negedge clk);
      base_addr = 10'd100;
      count = 11'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(p);
      repeat (3) @(negedge clk);
      chk("t6_no_addr100", hit100, 0);
      chk("t6_one_done", done_seen, p + 1);
      // oversized count clamps to 1024 words
      rmode = 0;
      p = done_seen;
      issue(700, 1500);
      wait_done(p);
      // random blocks
      for (int k = 0; k < 25; k++) begin
         for (int j = 0; j < 4; j++) mem[$urandom_range(0, 1023)] = {16'($urandom), 32'($urandom)};
         rmode = $urandom_range(0, 2);
         p = done_seen;
         issue($urandom_range(0, 1023), $urandom_range(0, 8));
         wait_done(p);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
